// File: rtl/dffram_host_pkg.sv
// Shared types and helpers for the DFFRAM tile host bridge.
// Pin byte layout is {we, word[4:0], byte[1:0]}.
package dffram_host_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_AW        = 5;
  localparam int WE_BIT         = 7;

  function automatic logic [7:0] pin_byte(input logic we, input logic [WORD_AW-1:0] word,
                                          input logic [1:0] b);
    return {we, word, b};
  endfunction

  // Index of the lowest set bit; callers guarantee a non-zero mask.
  function automatic logic [1:0] lowest_byte(input logic [BYTES_PER_WORD-1:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/dffram_host_bridge.sv
// Host-side initiator: turns 32-bit word requests into byte-serial beats
// on the DFFRAM tile pins and assembles read bytes into a response.
module dffram_host_bridge
  import dffram_host_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [7:0]  pin_ui,
  output logic [7:0]  pin_uio,
  input  logic [7:0]  pin_uo,
  output logic        ram_en
);

  localparam int WAIT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_e              state_q, state_d;
  logic [WORD_AW-1:0]  word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [1:0]          byte_q, byte_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [7:0]          ui_q, ui_d, uio_q, uio_d;
  logic                en_q;
  logic [1:0]          first_b, next_b;

  // ram_en gates acceptance so req_ready stays low until the tile is enabled
  assign req_ready = (state_q == S_IDLE) && en_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign pin_ui    = ui_q;
  assign pin_uio   = uio_q;
  assign ram_en    = en_q;

  assign first_b = lowest_byte(req_be);
  assign next_b  = lowest_byte(be_q);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    ui_d    = ui_q;
    uio_d   = uio_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          word_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          byte_d  = 2'd0;
          wait_d  = '0;
          if (req_we) begin
            if (req_be != 4'b0000) begin
              // first enabled byte goes out on the edge that accepts the request
              ui_d    = pin_byte(1'b1, req_addr, first_b);
              uio_d   = req_wdata[{first_b, 3'b000} +: 8];
              be_d    = req_be & ~(4'b0001 << first_b);
              state_d = S_WR;
            end else begin
              state_d = S_RESP;
            end
          end else begin
            ui_d    = pin_byte(1'b0, req_addr, 2'd0);
            state_d = S_RD;
          end
        end
      end
      S_WR: begin
        if (be_q != 4'b0000) begin
          ui_d  = pin_byte(1'b1, word_q, next_b);
          uio_d = wdata_q[{next_b, 3'b000} +: 8];
          be_d  = be_q & ~(4'b0001 << next_b);
        end else begin
          ui_d[WE_BIT] = 1'b0;
          uio_d        = 8'h00;
          state_d      = S_RESP;
        end
      end
      S_RD: begin
        if (wait_q == WAIT_W'(RD_LAT)) begin
          rdata_d[{byte_q, 3'b000} +: 8] = pin_uo;
          wait_d = '0;
          if (byte_q == 2'd3) begin
            state_d = S_RESP;
          end else begin
            byte_d = byte_q + 2'd1;
            ui_d   = pin_byte(1'b0, word_q, byte_q + 2'd1);
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      byte_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      ui_q    <= '0;
      uio_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
      en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dffram_host_bridge.sv
// Bench for dffram_host_bridge: behavioural DFFRAM tile responder plus a
// word-level shadow memory as the reference for every transaction.
module tb_dffram_host_bridge;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [7:0]  pin_ui, pin_uio, pin_uo;
  logic        ram_en;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] shadow [32];

  dffram_host_bridge #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo), .ram_en(ram_en)
  );

  always #5 clk = ~clk;

  // Tile responder: byte write on WE, read data after RD_LAT edges.
  logic [31:0] tile_mem [32];
  logic [7:0]  rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_en && pin_ui[7])
      tile_mem[pin_ui[6:2]][{pin_ui[1:0], 3'b000} +: 8] <= pin_uio;
    rd_pipe[0] <= tile_mem[pin_ui[6:2]][{pin_ui[1:0], 3'b000} +: 8];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign pin_uo = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request/response; starts and ends at a negedge in an IDLE cycle.
  task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, output logic [31:0] rd);
    int waits, cyc, exp_lat;
    logic [15:0] got [$];
    logic [15:0] exp [$];
    logic [31:0] exp_rd;
    for (int b = 0; b < 4; b++) begin
      if (we) begin
        if (be[b]) exp.push_back({1'b1, a, 2'(b), 8'(wd >> (8 * b))});
      end else begin
        for (int k = 0; k <= RD_LAT; k++) exp.push_back({1'b0, a, 2'(b), 8'h00});
      end
    end
    exp_rd  = we ? 32'h0 : shadow[a];
    exp_lat = we ? $countones(be) + 1 : 4 * (RD_LAT + 1) + 1;
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];

    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    waits = 0;
    while (!req_ready && waits < 200) begin @(negedge clk); waits++; end
    check("accept_wait", 32'(waits), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      got.push_back({pin_ui, pin_uio});
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("beat_count", 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check("beat", {16'h0, got[i]}, {16'h0, exp[i]});
    check("rdata", rsp_rdata, exp_rd);
    check("we_low_in_resp", {31'h0, pin_ui[7]}, 32'h0);
    rd = rsp_rdata;
    // backpressure with a junk request that must be ignored
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = ~wd; req_be = 4'hF;
      @(negedge clk);
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_ready", {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_ready", {31'h0, req_ready}, 32'h1);
    check("idle_no_rsp", {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

    #22;
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_pin_ui", {24'h0, pin_ui}, 32'h0);
    check("rst_pin_uio", {24'h0, pin_uio}, 32'h0);
    check("rst_ram_en", {31'h0, ram_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ram_en_up", {31'h0, ram_en}, 32'h1);
    check("ready_up", {31'h0, req_ready}, 32'h1);

    // directed steps from the plan
    txn(1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 0, rd);
    txn(1'b0, 5'd5, 32'h0, 4'b0000, 0, rd);
    check("plan_full_rd", rd, 32'hDEADBEEF);
    txn(1'b1, 5'd5, 32'h11223344, 4'b0101, 0, rd);
    txn(1'b0, 5'd5, 32'h0, 4'b0000, 0, rd);
    check("plan_partial_rd", rd, 32'hDE22BE44);
    txn(1'b1, 5'd5, 32'hCAFEF00D, 4'b0000, 0, rd);
    txn(1'b0, 5'd5, 32'h0, 4'b0000, 10, rd);
    check("plan_be0_rd", rd, 32'hDE22BE44);

    // fill every word, then a random mix with random backpressure
    for (int a = 0; a < 32; a++) txn(1'b1, 5'(a), $urandom, 4'hF, 0, rd);
    for (int n = 0; n < 60; n++)
      txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          4'($urandom_range(0, 15)), $urandom_range(0, 3), rd);

    // reset during the second beat of a full write to word 9
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 32'hA1B2C3D4; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_beat0", {24'h0, pin_ui}, 32'hA4);
    @(negedge clk);
    check("rst_beat1", {24'h0, pin_ui}, 32'hA5);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_pin_ui", {24'h0, pin_ui}, 32'h0);
    check("midrst_pin_uio", {24'h0, pin_uio}, 32'h0);
    check("midrst_ram_en", {31'h0, ram_en}, 32'h0);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    check("midrst_ready", {31'h0, req_ready}, 32'h1);
    shadow[9][7:0] = 8'hD4;
    check("midrst_tile_mem", tile_mem[9], shadow[9]);
    txn(1'b0, 5'd9, 32'h0, 4'b0000, 0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dffram_host_bridge.md
# dffram_host_bridge

Host-side initiator for the byte-serial DFFRAM tile pin interface. Accepts 32-bit word read/write requests on a valid/ready port. Sequences each request into byte-wide pin beats: `{WE, addr[6:0]}` on the tile's dedicated inputs, write data on its bidirectional inputs, and read data sampled from its dedicated outputs. Used in the test harness and in the FPGA/MCU-side controller that drives the RAM tile.

## Interface
- `RD_LAT`, default 1: tile read latency in cycles, address-valid cycle to data-valid cycle (≥1).
- `clk` in 1: single clock, shared with the tile.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge idle, accepts request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 5: word address (32 words).
- `req_wdata` in 32: write word, byte 0 = bits 7:0.
- `req_be` in 4: write byte enables. Ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: read word. 0 for writes.
- `pin_ui` out 8: to tile `ui_in`, `{WE, word[4:0], byte[1:0]}`.
- `pin_uio` out 8: to tile `uio_in`, write byte.
- `pin_uo` in 8: from tile `uo_out`, read byte.
- `ram_en` out 1: to tile `rst_n`/enable.

## Operation
- States: IDLE, WR, RD, RESP.
- IDLE: `req_ready`=1. On handshake, latch the request.
  - Write with `req_be`≠0: go to WR.
  - Write with `req_be`=0: go to RESP directly; no pin activity.
  - Read: go to RD.
- WR: one cycle per enabled byte, in ascending byte order. Disabled bytes are skipped with no idle cycle.
  - Per beat: `pin_ui`={1, word, b} and `pin_uio`=wdata[8b+:8].
  - After the last enabled byte, go to RESP.
- RD: bytes 0..3. Each byte occupies RD_LAT+1 cycles with `pin_ui`={0, word, b} held.
  - `pin_uo` is captured into rdata[8b+:8] at the clock edge ending the last cycle of that byte.
  - After byte 3 is captured, go to RESP.
- RESP: `rsp_valid`=1. `rsp_rdata` is stable. When `rsp_ready`=1, go to IDLE next cycle.
- Outside WR, `pin_ui[7]`=0 and `pin_uio`=0. `pin_ui[6:0]` holds its last driven value.
- Byte/beat counter is 2 bits. The wait counter is sized for RD_LAT.

## Timing
- Reset values: `req_ready`=0 during reset, then 1 (IDLE). `rsp_valid`=0, `rsp_rdata`=0, `pin_ui`=0, `pin_uio`=0, `ram_en`=0.
- `ram_en` is registered. It rises on the first clock edge after reset release and stays high.
- All pin outputs are registered. The first beat appears the cycle after the request handshake.
- Write latency, handshake to `rsp_valid`: popcount(be)+1 cycles. For be=0: 1 cycle.
- Read latency: 4·(RD_LAT+1)+1 cycles. Default is 9.
- One bubble between transactions: IDLE lasts at least 1 cycle after RESP.
- `rsp_valid`/`rsp_rdata` must hold while `rsp_ready`=0.
- Reset mid-transaction: all outputs return to reset values asynchronously. `pin_ui[7]` drops immediately, so no partial write beat completes after reset assertion. The in-flight request is dropped with no response.
- `req_*` is ignored when `req_ready`=0.

## Structure
- Package `dffram_host_pkg`:
  - state enum
  - `BYTES_PER_WORD`=4
  - `WORD_AW`=5
  - `WE_BIT`=7
  - helper function packing `{we, word, byte}` into the pin byte
- Single module, no sub-module. The tile itself is instantiated only in the testbench, as the behavioural responder.

## Test plan
- Full write: word 5, data 0xDEADBEEF, be=1111.
  - `pin_ui` = 0x94, 0x95, 0x96, 0x97 on consecutive cycles.
  - `pin_uio` = 0xEF, 0xBE, 0xAD, 0xDE.
  - `rsp_valid` 5 cycles after the handshake.
- Read back word 5 with RD_LAT=1:
  - `pin_ui` = 0x14, 0x14, 0x15, 0x15, 0x16, 0x16, 0x17, 0x17.
  - `rsp_rdata`=0xDEADBEEF after 9 cycles.
- Partial write: be=0101, data 0x11223344 to word 5.
  - Exactly two beats: 0x94/0x44, then 0x96/0x22.
  - Readback = 0xDE22BE44.
- be=0000 write:
  - No pin beat; `pin_ui[7]` stays 0.
  - `rsp_valid` 1 cycle after the handshake.
- Response backpressure: hold `rsp_ready`=0 for 10 cycles.
  - `rsp_valid`/`rsp_rdata` stable.
  - `req_ready`=0 throughout.
  - Next request is accepted 1 cycle after `rsp_ready`.
- Reset asserted during the second write beat:
  - `pin_ui`=0 and `ram_en`=0 immediately.
  - After release, `req_ready`=1 and no response is produced.
  - The RAM model shows only byte 0 written.
